lane_gearbox_align: RTL and testbench

- Parametrised single-clock gearbox with word alignment. It is the successor of the fixed 1:10 deserializer lane.
- It accepts IN_W-bit parallel fragments from an IDDR/ISERDES primitive and reassembles them into OUT_W-bit words.
- Word boundary is adjusted by bitslip, either driven manually or found automatically by searching for TMDS control tokens.
- Sits between the per-lane IO primitive wrapper and the TMDS decoder / channel deskew logic of hdmi_in.

---
 rtl/lane_gearbox_align_if.sv | 38 +++
 rtl/lane_gearbox_align.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_lane_gearbox_align.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_gearbox_align_if.sv
// ---------------------------------------------------------------------------
// lane_gearbox_align_if
// Purpose : groups the fragment input, slip/restart controls and the aligned
//           word output of lane_gearbox_align into one bundle.
// Signals : I_din_valid / I_din      fragment strobe and serial-order fragment
//           I_bitslip                single-cycle manual slip request
//           I_align_restart          send the auto-align FSM back to SEARCH
//           O_dout / O_dout_valid    aligned word and its one-cycle strobe
//           O_locked                 automatic alignment locked
//           O_slip_cnt               slips applied, modulo OUT_W
// Modports: master drives the inputs (IO wrapper / bench side),
//           slave is the gearbox itself.
// ---------------------------------------------------------------------------
interface lane_gearbox_align_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 10
);
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic              I_din_valid;
    logic [IN_W-1:0]   I_din;
    logic              I_bitslip;
    logic              I_align_restart;
    logic [OUT_W-1:0]  O_dout;
    logic              O_dout_valid;
    logic              O_locked;
    logic [CNT_W-1:0]  O_slip_cnt;

    modport master (
        output I_din_valid, I_din, I_bitslip, I_align_restart,
        input  O_dout, O_dout_valid, O_locked, O_slip_cnt
    );

    modport slave (
        input  I_din_valid, I_din, I_bitslip, I_align_restart,
        output O_dout, O_dout_valid, O_locked, O_slip_cnt
    );
endinterface

// File: rtl/lane_gearbox_align.sv
// ---------------------------------------------------------------------------
// lane_gearbox_align
// Purpose : single-clock IN_W -> OUT_W gearbox with word alignment by bitslip.
//           Fragments from the IO primitive are appended to an accumulator in
//           serial order; one oldest bit can be discarded per slip; whenever
//           OUT_W bits are available the oldest OUT_W become the output word.
//           The word boundary is moved manually (ALIGN_MODE=0, I_bitslip) or
//           by a TMDS control-token search (ALIGN_MODE=1, needs OUT_W=10).
// Ports   : I_clk            fragment/word clock
//           I_rst_n          asynchronous active-low reset
//           bus (slave)      fragment input, slip/restart, word output,
//                            lock flag and slip counter
//           O_fsm_state      alignment FSM state, 0=SEARCH 1=CHECK 2=LOCKED
// Handshake: I_din_valid qualifies I_din for exactly one cycle and there is
//           no backpressure; O_dout_valid is a one-cycle strobe marking a new
//           O_dout, which otherwise holds its last value.
// ---------------------------------------------------------------------------
module lane_gearbox_align #(
    parameter int IN_W         = 4,
    parameter int OUT_W        = 10,
    parameter int MSB_FIRST    = 1,
    parameter int ALIGN_MODE   = 0,
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WORDS = 2048,
    parameter int LOST_WORDS   = 4096
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    lane_gearbox_align_if.slave   bus,
    output logic [1:0]            O_fsm_state
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int BUF_W    = OUT_W + IN_W;
    localparam int FILL_W   = $clog2(BUF_W + 1);
    localparam int CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int MAX_MISS = (SEARCH_WORDS > LOST_WORDS) ? SEARCH_WORDS : LOST_WORDS;
    localparam int MISS_W   = $clog2(MAX_MISS + 1);
    localparam int RUN_W    = $clog2(LOCK_TOKENS + 1);

    localparam logic [FILL_W-1:0] IN_W_F     = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] OUT_W_F    = FILL_W'(OUT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(OUT_W - 1);
    localparam logic [MISS_W-1:0] SEARCH_LIM = MISS_W'(SEARCH_WORDS - 1);
    localparam logic [MISS_W-1:0] LOST_LIM   = MISS_W'(LOST_WORDS);
    localparam logic [RUN_W-1:0]  LOCK_LIM   = RUN_W'(LOCK_TOKENS);

    // Alignment FSM encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_buf holds bits in serial order: r_buf[0] is the oldest bit. Bits at
    // positions >= r_fill are always zero so appends can simply OR in.
    logic [BUF_W-1:0]  r_buf;
    logic [FILL_W-1:0] r_fill;
    logic              r_slip_pend;
    logic [CNT_W-1:0]  r_slip_cnt;
    logic [OUT_W-1:0]  r_dout;
    logic              r_dout_valid;
    logic [1:0]        r_state;
    logic [MISS_W-1:0] r_miss;
    logic [RUN_W-1:0]  r_run;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [BUF_W-1:0]  w_frag_ser;
    logic [BUF_W-1:0]  w_buf_a;
    logic [FILL_W-1:0] w_fill_a;
    logic              w_slip_do;
    logic [BUF_W-1:0]  w_buf_b;
    logic [FILL_W-1:0] w_fill_b;
    logic              w_emit;
    logic [OUT_W-1:0]  w_word_ser;
    logic [OUT_W-1:0]  w_word_out;
    logic [BUF_W-1:0]  w_buf_c;
    logic [FILL_W-1:0] w_fill_c;
    logic              w_slip_req;
    logic              w_slip_pend_n;

    // Fragment re-ordered so that bit 0 is the earliest received bit.
    always_comb begin
        w_frag_ser = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_frag_ser[i] = (MSB_FIRST != 0) ? bus.I_din[IN_W-1-i] : bus.I_din[i];
        end
    end

    // Step 1: append behind the bits already held.
    always_comb begin
        w_buf_a  = r_buf;
        w_fill_a = r_fill;
        if (bus.I_din_valid) begin
            w_buf_a  = r_buf | (w_frag_ser << r_fill);
            w_fill_a = r_fill + IN_W_F;
        end
    end

    // Step 2: a pending slip drops the oldest bit, but only once a bit exists.
    assign w_slip_do = r_slip_pend && (w_fill_a != '0);

    always_comb begin
        w_buf_b  = w_buf_a;
        w_fill_b = w_fill_a;
        if (w_slip_do) begin
            w_buf_b  = w_buf_a >> 1;
            w_fill_b = w_fill_a - FILL_W'(1);
        end
    end

    // Step 3: emit the oldest OUT_W bits when enough are held. r_fill never
    // exceeds OUT_W-1 after a cycle, so at most one word per cycle is ready.
    assign w_emit     = (w_fill_b >= OUT_W_F);
    assign w_word_ser = w_buf_b[OUT_W-1:0];

    always_comb begin
        w_buf_c  = w_buf_b;
        w_fill_c = w_fill_b;
        if (w_emit) begin
            w_buf_c  = w_buf_b >> OUT_W;
            w_fill_c = w_fill_b - OUT_W_F;
        end
    end

    // Serial word mapped onto the output bit order.
    always_comb begin
        w_word_out = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (MSB_FIRST != 0) begin
                w_word_out[OUT_W-1-k] = w_word_ser[k];
            end else begin
                w_word_out[k] = w_word_ser[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Token detection on the registered word
    // ------------------------------------------------------------------
    // Tokens are defined with the earliest bit as MSB, so an LSB-first word
    // is reversed before comparison.
    logic [OUT_W-1:0] w_dout_msb;
    logic [9:0]       w_tok_src;
    logic             w_is_tok;

    always_comb begin
        w_dout_msb = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (MSB_FIRST != 0) begin
                w_dout_msb[k] = r_dout[k];
            end else begin
                w_dout_msb[k] = r_dout[OUT_W-1-k];
            end
        end
    end

    assign w_tok_src = 10'(w_dout_msb);
    assign w_is_tok  = (w_tok_src == 10'h354) || (w_tok_src == 10'h0AB) ||
                       (w_tok_src == 10'h154) || (w_tok_src == 10'h2AB);

    // ------------------------------------------------------------------
    // Alignment FSM, evaluated on cycles where O_dout_valid is high
    // ------------------------------------------------------------------
    logic [1:0]        w_state_n;
    logic [MISS_W-1:0] w_miss_n;
    logic [RUN_W-1:0]  w_run_n;
    logic              w_auto_slip;
    logic [MISS_W-1:0] w_miss_inc;
    logic [RUN_W-1:0]  w_run_inc;

    assign w_miss_inc = r_miss + MISS_W'(1);
    assign w_run_inc  = r_run + RUN_W'(1);

    always_comb begin
        w_state_n   = r_state;
        w_miss_n    = r_miss;
        w_run_n     = r_run;
        w_auto_slip = 1'b0;
        if (ALIGN_MODE != 0) begin
            if (bus.I_align_restart) begin
                w_state_n = ST_SEARCH;
                w_miss_n  = '0;
                w_run_n   = '0;
            end else if (r_dout_valid) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_is_tok) begin
                            w_state_n = ST_CHECK;
                            w_run_n   = RUN_W'(1);
                            w_miss_n  = '0;
                        end else if (!r_slip_pend) begin
                            // Words still carrying the old boundary while a
                            // slip waits are not counted against the new one.
                            if (w_miss_inc == SEARCH_LIM) begin
                                w_auto_slip = 1'b1;
                                w_miss_n    = '0;
                            end else begin
                                w_miss_n = w_miss_inc;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (w_is_tok) begin
                            w_run_n = w_run_inc;
                            if (w_run_inc == LOCK_LIM) begin
                                w_state_n = ST_LOCKED;
                                w_miss_n  = '0;
                            end
                        end else begin
                            // Data periods are legal, so fall back without a slip.
                            w_state_n = ST_SEARCH;
                            w_run_n   = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_is_tok) begin
                            w_miss_n = '0;
                        end else if (w_miss_inc == LOST_LIM) begin
                            w_state_n = ST_SEARCH;
                            w_miss_n  = '0;
                            w_run_n   = '0;
                        end else begin
                            w_miss_n = w_miss_inc;
                        end
                    end
                    default: begin
                        w_state_n = ST_SEARCH;
                        w_miss_n  = '0;
                        w_run_n   = '0;
                    end
                endcase
            end
        end
    end

    // A request arriving while a slip is already pending is dropped.
    assign w_slip_req    = (ALIGN_MODE != 0) ? w_auto_slip : bus.I_bitslip;
    assign w_slip_pend_n = r_slip_pend ? !w_slip_do : w_slip_req;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_buf        <= '0;
            r_fill       <= '0;
            r_slip_pend  <= 1'b0;
            r_slip_cnt   <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_state      <= ST_SEARCH;
            r_miss       <= '0;
            r_run        <= '0;
        end else begin
            r_buf        <= w_buf_c;
            r_fill       <= w_fill_c;
            r_slip_pend  <= w_slip_pend_n;
            if (w_slip_do) begin
                r_slip_cnt <= (r_slip_cnt == CNT_MAX) ? '0 : r_slip_cnt + CNT_W'(1);
            end
            r_dout_valid <= w_emit;
            if (w_emit) begin
                r_dout <= w_word_out;
            end
            r_state      <= w_state_n;
            r_miss       <= w_miss_n;
            r_run        <= w_run_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.O_dout       = r_dout;
    assign bus.O_dout_valid = r_dout_valid;
    assign bus.O_locked     = (ALIGN_MODE != 0) && (r_state == ST_LOCKED);
    assign bus.O_slip_cnt   = r_slip_cnt;
    assign O_fsm_state      = r_state;

endmodule

// File: tb/tb_lane_gearbox_align.sv
// ---------------------------------------------------------------------------
// tb_lane_gearbox_align
// Two gearboxes share clock and reset: u_man (defaults, manual slips) and
// u_aut (automatic token search, SEARCH_WORDS=16, LOST_WORDS=16). Each lane
// has a bit-level source stream and a bit-queue reference model; a compare
// process checks every output of both lanes on every falling clock edge,
// and directed steps pin the model with hand-derived values.
// ---------------------------------------------------------------------------
module tb_lane_gearbox_align;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam int A_SEARCH = 16;
    localparam int A_LOST   = 16;
    localparam int A_LOCK   = 8;

    lane_gearbox_align_if #(.IN_W(4), .OUT_W(10)) if_man ();
    lane_gearbox_align_if #(.IN_W(4), .OUT_W(10)) if_aut ();
    logic [1:0] st_man;
    logic [1:0] st_aut;

    lane_gearbox_align u_man (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .bus         (if_man),
        .O_fsm_state (st_man)
    );

    lane_gearbox_align #(
        .ALIGN_MODE   (1),
        .SEARCH_WORDS (A_SEARCH),
        .LOST_WORDS   (A_LOST)
    ) u_aut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .bus         (if_aut),
        .O_fsm_state (st_aut)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // ------------------------------------------------------------------
    // Source streams (serial bit order, index 0 = earliest)
    // ------------------------------------------------------------------
    bit         src [2][0:16383];
    int         src_wr [2];
    int         src_rd [2];
    bit         refill [2];
    bit         in_v [2];
    logic [3:0] in_din [2];
    bit         bs_man = 1'b0;
    bit         rs_aut = 1'b0;

    task automatic push_word(input int d, input logic [9:0] w);
        for (int k = 9; k >= 0; k--) begin
            src[d][src_wr[d]] = w[k];
            src_wr[d]++;
        end
    endtask

    // Stream of repeating 10'h354 delayed by 'off' bits: the first bits are
    // the tail of a token, so the first full token starts at bit 'off'.
    task automatic src_init(input int d, input int off, input bit fill_on);
        logic [9:0] tok;
        tok       = 10'h354;
        src_wr[d] = 0;
        src_rd[d] = 0;
        refill[d] = fill_on;
        for (int b = off - 1; b >= 0; b--) begin
            src[d][src_wr[d]] = tok[b];
            src_wr[d]++;
        end
    endtask

    task automatic feed_all();
        for (int d = 0; d < 2; d++) begin
            if (refill[d] && (src_wr[d] - src_rd[d] < 4)) push_word(d, 10'h354);
            if (src_wr[d] - src_rd[d] >= 4) begin
                in_v[d]   = 1'b1;
                in_din[d] = {src[d][src_rd[d]], src[d][src_rd[d]+1],
                             src[d][src_rd[d]+2], src[d][src_rd[d]+3]};
                src_rd[d] += 4;
            end else begin
                in_v[d]   = 1'b0;
                in_din[d] = 4'h0;
            end
        end
        if_man.I_din_valid     = in_v[0];
        if_man.I_din           = in_din[0];
        if_man.I_bitslip       = bs_man;
        if_man.I_align_restart = 1'b0;
        if_aut.I_din_valid     = in_v[1];
        if_aut.I_din           = in_din[1];
        if_aut.I_bitslip       = 1'b0;
        if_aut.I_align_restart = rs_aut;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a bit queue plus the alignment rules
    // ------------------------------------------------------------------
    bit         mbuf [2][0:31];
    int         mcnt [2];
    bit         m_pend [2];
    int         m_scnt [2];
    logic [9:0] m_dout [2];
    bit         m_dv [2];
    bit         m_locked [2];
    int         m_state [2];   // 0 SEARCH, 1 CHECK, 2 LOCKED
    int         m_miss [2];
    int         m_run [2];

    task automatic model_reset(input int d);
        mcnt[d]     = 0;
        m_pend[d]   = 1'b0;
        m_scnt[d]   = 0;
        m_dout[d]   = 10'h0;
        m_dv[d]     = 1'b0;
        m_locked[d] = 1'b0;
        m_state[d]  = 0;
        m_miss[d]   = 0;
        m_run[d]    = 0;
    endtask

    task automatic drop_front(input int d, input int n);
        for (int j = 0; j < mcnt[d] - n; j++) mbuf[d][j] = mbuf[d][j+n];
        mcnt[d] -= n;
    endtask

    task automatic model_step(input int d, input bit v, input logic [3:0] din,
                              input bit bs, input bit rs);
        bit         old_pend;
        bit         req;
        bit         cons;
        bit         tok;
        logic [9:0] w;
        old_pend = m_pend[d];
        req      = 1'b0;
        cons     = 1'b0;
        if (d == 1) begin
            if (rs) begin
                m_state[d] = 0;
                m_miss[d]  = 0;
                m_run[d]   = 0;
            end else if (m_dv[d]) begin
                tok = is_token(m_dout[d]);
                if (m_state[d] == 0) begin
                    if (tok) begin
                        m_state[d] = 1;
                        m_run[d]   = 1;
                        m_miss[d]  = 0;
                    end else if (!old_pend) begin
                        m_miss[d]++;
                        if (m_miss[d] == A_SEARCH - 1) begin
                            req       = 1'b1;
                            m_miss[d] = 0;
                        end
                    end
                end else if (m_state[d] == 1) begin
                    if (tok) begin
                        m_run[d]++;
                        if (m_run[d] == A_LOCK) begin
                            m_state[d] = 2;
                            m_miss[d]  = 0;
                        end
                    end else begin
                        m_state[d] = 0;
                        m_run[d]   = 0;
                    end
                end else begin
                    if (tok) begin
                        m_miss[d] = 0;
                    end else begin
                        m_miss[d]++;
                        if (m_miss[d] == A_LOST) begin
                            m_state[d] = 0;
                            m_miss[d]  = 0;
                        end
                    end
                end
            end
        end else begin
            req = bs;
        end
        if (v) begin
            for (int k = 3; k >= 0; k--) begin
                mbuf[d][mcnt[d]] = din[k];
                mcnt[d]++;
            end
        end
        if (old_pend && mcnt[d] >= 1) begin
            drop_front(d, 1);
            m_scnt[d] = (m_scnt[d] + 1) % 10;
            cons      = 1'b1;
        end
        if (mcnt[d] >= 10) begin
            for (int k = 0; k < 10; k++) w[9-k] = mbuf[d][k];
            drop_front(d, 10);
            m_dout[d] = w;
            m_dv[d]   = 1'b1;
        end else begin
            m_dv[d] = 1'b0;
        end
        m_pend[d]   = old_pend ? !cons : req;
        m_locked[d] = (d == 1) && (m_state[d] == 2);
    endtask

    // One clock: inputs are already applied; model advances at the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, in_v[0], in_din[0], bs_man, 1'b0);
            model_step(1, in_v[1], in_din[1], 1'b0, rs_aut);
        end
        @(negedge clk);
    endtask

    // Reset pulse between edges, with the asynchronous values pinned.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check({tag, "_man_dout"},   32'(if_man.O_dout),       32'h0);
        check({tag, "_man_dv"},     32'(if_man.O_dout_valid), 32'h0);
        check({tag, "_man_slip"},   32'(if_man.O_slip_cnt),   32'h0);
        check({tag, "_aut_dout"},   32'(if_aut.O_dout),       32'h0);
        check({tag, "_aut_locked"}, 32'(if_aut.O_locked),     32'h0);
        check({tag, "_aut_slip"},   32'(if_aut.O_slip_cnt),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("man_dout",   32'(if_man.O_dout),       32'(m_dout[0]));
            check("man_dv",     32'(if_man.O_dout_valid), 32'(m_dv[0]));
            check("man_locked", 32'(if_man.O_locked),     32'(m_locked[0]));
            check("man_slip",   32'(if_man.O_slip_cnt),   32'(m_scnt[0]));
            check("aut_dout",   32'(if_aut.O_dout),       32'(m_dout[1]));
            check("aut_dv",     32'(if_aut.O_dout_valid), 32'(m_dv[1]));
            check("aut_locked", 32'(if_aut.O_locked),     32'(m_locked[1]));
            check("aut_slip",   32'(if_aut.O_slip_cnt),   32'(m_scnt[1]));
            check("aut_state",  32'(st_aut),              32'(m_state[1]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int  dv_cnt;
        bit  found;
        logic [9:0] rw;

        model_reset(0);
        model_reset(1);
        src_init(0, 0, 1'b0);
        src_init(1, 0, 1'b0);
        feed_all();
        repeat (3) cyc();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        check("rst_man_dout",   32'(if_man.O_dout),       32'h0);
        check("rst_man_dv",     32'(if_man.O_dout_valid), 32'h0);
        check("rst_man_slip",   32'(if_man.O_slip_cnt),   32'h0);
        check("rst_aut_locked", 32'(if_aut.O_locked),     32'h0);

        // 1: aligned token stream, continuous valid
        src_init(0, 0, 1'b1);
        feed_all(); cyc();
        feed_all(); cyc();
        check("t1_no_word_yet", 32'(if_man.O_dout_valid), 32'h0);
        feed_all(); cyc();
        check("t1_first_dv",   32'(if_man.O_dout_valid), 32'h1);
        check("t1_first_word", 32'(if_man.O_dout),       32'h354);
        dv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            feed_all(); cyc();
            if (if_man.O_dout_valid) dv_cnt++;
        end
        check("t1_rate_4_per_10", 32'(dv_cnt), 32'd4);
        check("t1_slip", 32'(if_man.O_slip_cnt), 32'h0);

        // 2: stream delayed by 3 bits, three manual slips
        do_reset("t2rst");
        src_init(0, 3, 1'b1);
        for (int i = 0; i < 45; i++) begin
            bs_man = (i == 5) || (i == 15) || (i == 25);
            feed_all(); cyc();
        end
        bs_man = 1'b0;
        check("t2_word", 32'(if_man.O_dout),     32'h354);
        check("t2_slip", 32'(if_man.O_slip_cnt), 32'd3);

        // 3: slip with empty buffer, second request while pending is dropped
        do_reset("t3rst");
        src_init(0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bs_man = (i == 0) || (i == 3);
            feed_all(); cyc();
        end
        bs_man = 1'b0;
        check("t3_slip_waiting", 32'(if_man.O_slip_cnt), 32'h0);
        src_init(0, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            feed_all(); cyc();
        end
        check("t3_slip", 32'(if_man.O_slip_cnt), 32'd1);
        check("t3_word", 32'(if_man.O_dout),     32'h354);

        // 4: automatic search on a stream offset by 7 bits
        src_init(1, 7, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            feed_all(); cyc();
            if (if_aut.O_locked) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_lock_seen", 32'(found),             32'h1);
        check("t4_slip",      32'(if_aut.O_slip_cnt), 32'd7);
        check("t4_state",     32'(st_aut),            32'd2);

        // 5: twenty non-token words while locked
        refill[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do rw = 10'($urandom_range(0, 1023)); while (is_token(rw));
            push_word(1, rw);
        end
        for (int i = 0; i < 80; i++) begin
            feed_all(); cyc();
        end
        check("t5_unlocked", 32'(if_aut.O_locked),   32'h0);
        check("t5_search",   32'(st_aut),            32'd0);
        check("t5_slip",     32'(if_aut.O_slip_cnt), 32'd7);

        // 6: relock, reset mid-operation, realign
        refill[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            feed_all(); cyc();
            if (if_aut.O_locked) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_relock", 32'(found), 32'h1);
        do_reset("t6rst");
        src_init(0, 0, 1'b1);
        src_init(1, 7, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            feed_all(); cyc();
            if (if_aut.O_locked) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_lock_after_reset", 32'(found),             32'h1);
        check("t6_aut_slip",         32'(if_aut.O_slip_cnt), 32'd7);
        check("t6_man_word",         32'(if_man.O_dout),     32'h354);
        check("t6_man_slip",         32'(if_man.O_slip_cnt), 32'h0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
